// File: rtl/sha256_pkg.sv
// Shared types and helpers for the SHA-256 message loader and its byte packer.
package sha256_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_START     = 3'd2,
      ST_WAIT_BUSY = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_RD_ADDR   = 3'd5,
      ST_RD_CAP    = 3'd6,
      ST_OUT       = 3'd7
   } state_e;

   localparam int DIGEST_WORDS = 8;

   // Big-endian pack: earlier bytes drift toward bit 31 as later bytes arrive.
   function automatic logic [31:0] pack_byte(input logic [31:0] word, input logic [7:0] byte_in);
      return {word[23:0], byte_in};
   endfunction

endpackage

// File: rtl/sha256_msg_loader_if.sv
// Control, byte-stream, memory, engine and digest-stream signals of the message loader.
interface sha256_msg_loader_if;

   logic        go;
   logic [15:0] input_addr;
   logic [15:0] hash_addr;
   logic        busy;

   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;

   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic        sha_start;
   logic        sha_done;
   logic        sha_active;

   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;

   modport master (
      input  go, input_addr, hash_addr, in_valid, in_data, mem_rdata, sha_done, out_ready,
      output busy, in_ready, mem_we, mem_addr, mem_wdata, sha_start, sha_active, out_valid, out_data
   );

   modport slave (
      output go, input_addr, hash_addr, in_valid, in_data, mem_rdata, sha_done, out_ready,
      input  busy, in_ready, mem_we, mem_addr, mem_wdata, sha_start, sha_active, out_valid, out_data
   );

endinterface

// File: rtl/sha256_byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words; flags each completed word combinationally
// together with its index so the caller can register the memory write on the next cycle.
module sha256_byte_packer
   import sha256_pkg::*;
#(
   parameter  int NUM_OF_WORDS = 40,
   localparam int IDX_W        = $clog2(NUM_OF_WORDS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             word_valid,
   output logic [31:0]      word_data,
   output logic [IDX_W-1:0] word_idx,
   output logic             words_done
);

   logic [1:0]       byte_cnt_q, byte_cnt_d;
   logic [31:0]      pack_q, pack_d;
   logic [IDX_W-1:0] word_cnt_q, word_cnt_d;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      byte_cnt_d = byte_cnt_q;
      pack_d     = pack_q;
      word_cnt_d = word_cnt_q;
      word_valid = 1'b0;
      word_data  = pack_byte(pack_q, byte_data);
      word_idx   = word_cnt_q;

      if (clear) begin
         byte_cnt_d = '0;
         pack_d     = '0;
         word_cnt_d = '0;
      end else if (byte_valid) begin
         pack_d     = word_data;
         byte_cnt_d = byte_cnt_q + 2'd1;
         if (byte_cnt_q == 2'd3) begin
            word_valid = 1'b1;
            word_cnt_d = word_cnt_q + IDX_W'(1);
         end
      end
   end

   assign words_done = (word_cnt_q == IDX_W'(NUM_OF_WORDS));

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt_q <= '0;
         pack_q     <= '0;
         word_cnt_q <= '0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         pack_q     <= pack_d;
         word_cnt_q <= word_cnt_d;
      end
   end

endmodule

// File: rtl/sha256_msg_loader.sv
// Streams a message into shared memory, kicks the SHA-256 engine, then reads the digest back
// out as a valid/ready word stream. Every output is a flop updated together with the state.
module sha256_msg_loader
   import sha256_pkg::*;
#(
   parameter int NUM_OF_WORDS = 40
) (
   input  logic                clk,
   input  logic                rst_n,
   sha256_msg_loader_if.master bus
);

   localparam int IDX_W = $clog2(NUM_OF_WORDS + 1);

   state_e      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic        in_ready_q, in_ready_d;
   logic        mem_we_q, mem_we_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        sha_start_q, sha_start_d;
   logic        sha_active_q, sha_active_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_data_q, out_data_d;
   logic        busy_q, busy_d;

   logic             word_valid;
   logic [31:0]      word_data;
   logic [IDX_W-1:0] word_idx;
   logic             words_done;

   sha256_byte_packer #(.NUM_OF_WORDS(NUM_OF_WORDS)) u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      ((state_q == ST_IDLE) && bus.go),
      .byte_valid (bus.in_valid && in_ready_q),
      .byte_data  (bus.in_data),
      .word_valid (word_valid),
      .word_data  (word_data),
      .word_idx   (word_idx),
      .words_done (words_done)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      in_ready_d   = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      sha_start_d  = 1'b0;
      sha_active_d = sha_active_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.go) begin
               state_d    = ST_LOAD;
               in_ready_d = 1'b1;
            end
         end
         ST_LOAD: begin
            in_ready_d = in_ready_q;
            if (word_valid) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = bus.input_addr + 16'(word_idx);
               mem_wdata_d = word_data;
               if (word_idx == IDX_W'(NUM_OF_WORDS - 1)) in_ready_d = 1'b0;
            end
            // words_done first rises during the final write cycle.
            if (words_done) begin
               state_d      = ST_START;
               sha_start_d  = 1'b1;
               sha_active_d = 1'b1;
            end
         end
         ST_START: state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (!bus.sha_done) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (bus.sha_done) begin
               sha_active_d = 1'b0;
               idx_d        = '0;
               mem_addr_d   = bus.hash_addr;
               state_d      = ST_RD_ADDR;
            end
         end
         ST_RD_ADDR: state_d = ST_RD_CAP;
         ST_RD_CAP: begin
            out_data_d  = bus.mem_rdata;
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
         end
         ST_OUT: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
               if (idx_q == 3'(DIGEST_WORDS - 1)) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d      = idx_q + 3'd1;
                  mem_addr_d = bus.hash_addr + 16'(idx_q + 3'd1);
                  state_d    = ST_RD_ADDR;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         in_ready_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         sha_start_q  <= 1'b0;
         sha_active_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         in_ready_q   <= in_ready_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         sha_start_q  <= sha_start_d;
         sha_active_q <= sha_active_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.sha_start  = sha_start_q;
   assign bus.sha_active = sha_active_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sha256_msg_loader.sv
// Scoreboard bench for sha256_msg_loader: expected writes and digest words are queued by the
// stimulus and popped by a negedge monitor; a small engine model and memory model sit alongside.
module tb_sha256_msg_loader;

   localparam int          NW      = 40;
   localparam logic [15:0] IN_ADDR = 16'h0100;

   typedef struct packed {
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sha256_msg_loader_if bus();

   sha256_msg_loader #(.NUM_OF_WORDS(NW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [31:0] exp_word(input int base, input int k);
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(base + 4*k);
      b1 = 8'(base + 4*k + 1);
      b2 = 8'(base + 4*k + 2);
      b3 = 8'(base + 4*k + 3);
      return {b0, b1, b2, b3};
   endfunction

   // Memory model with one-cycle read latency and a side port for preloading the digest.
   wr_t         exp_wr[$];
   logic [31:0] exp_out[$];
   logic [31:0] mem [0:65535];
   logic        pl_we   = 1'b0;
   logic [15:0] pl_addr = '0;
   logic [31:0] pl_data = '0;

   always @(posedge clk) begin
      if (pl_we) mem[pl_addr] <= pl_data;
      else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   // Engine model: sha_done stays high eng_hi cycles after start, low eng_lo cycles, then rises.
   int eng_hi        = 3;
   int eng_lo        = 20;
   int done_rise_cyc = -100;
   initial begin
      bus.sha_done = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.sha_start) begin
            repeat (eng_hi) @(posedge clk);
            #1 bus.sha_done = 1'b0;
            repeat (eng_lo) @(posedge clk);
            #1 bus.sha_done = 1'b1;
            done_rise_cyc = cyc;
         end
      end
   end

   int rdy_pct = 100;
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1 bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
      end
   end

   // Monitor: pops expectations whenever the DUT writes memory or hands over a digest word.
   int          wr_total      = 0;
   int          last_wr_cyc   = -1;
   int          out_total     = 0;
   int          first_out_cyc = -1;
   int          start_total   = 0;
   int          start_cyc     = -1;
   int          low_viol      = 0;
   logic        prev_hold     = 1'b0;
   logic        prev_valid    = 1'b0;
   logic [31:0] prev_data     = '0;
   wr_t         mon_e;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.mem_we) begin
            if (exp_wr.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_write: actual addr 0x%04h data 0x%08h, required no write",
                        bus.mem_addr, bus.mem_wdata);
            end else begin
               mon_e = exp_wr.pop_front();
               check("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
               check("wr_data", bus.mem_wdata, mon_e.data);
            end
            wr_total++;
            last_wr_cyc = cyc;
         end
         if (bus.sha_start) begin
            start_total++;
            start_cyc = cyc;
         end
         if (!bus.sha_done && (!bus.sha_active || !bus.busy || bus.in_ready || bus.out_valid || bus.mem_we))
            low_viol++;
         if (cyc == done_rise_cyc)     check("sha_active_before_drop", 32'(bus.sha_active), 1);
         if (cyc == done_rise_cyc + 1) check("sha_active_drop", 32'(bus.sha_active), 0);
         if (prev_hold) begin
            check("out_valid_hold", 32'(bus.out_valid), 1);
            check("out_data_hold", bus.out_data, prev_data);
         end
         if (bus.out_valid && !prev_valid && (out_total % 8 == 0)) first_out_cyc = cyc;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_out.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_digest: actual 0x%08h, required no word", bus.out_data);
            end else begin
               check("digest_word", bus.out_data, exp_out.pop_front());
            end
            out_total++;
         end
         prev_hold  = bus.out_valid && !bus.out_ready;
         prev_valid = bus.out_valid;
         prev_data  = bus.out_data;
      end else begin
         prev_hold  = 1'b0;
         prev_valid = 1'b0;
      end
   end

   task automatic preload(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_we   = 1'b1;
      pl_addr = a;
      pl_data = d;
      @(negedge clk);
      pl_we   = 1'b0;
   endtask

   task automatic pulse_go();
      @(posedge clk);
      #1 bus.go = 1'b1;
      @(posedge clk);
      #1 bus.go = 1'b0;
   endtask

   task automatic send_stream(input int base, input bit toggle, input int n,
                              output int first_acc, output int last_acc);
      int i     = 0;
      int guard = 0;
      bit ph    = 1'b1;
      first_acc = -1;
      last_acc  = -1;
      while (i < n && guard < 4*n + 50) begin
         @(negedge clk);
         guard++;
         bus.in_valid = toggle ? ph : 1'b1;
         ph           = ~ph;
         bus.in_data  = 8'(base + i);
         if (bus.in_valid && bus.in_ready) begin
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
            i++;
         end
      end
      check("stream_accepted", 32'(i), 32'(n));
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (n == 4*NW) check("in_ready_after_last", 32'(bus.in_ready), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"},   32'(bus.in_ready),   0);
      check({tag, "_mem_we"},     32'(bus.mem_we),     0);
      check({tag, "_mem_addr"},   32'(bus.mem_addr),   0);
      check({tag, "_mem_wdata"},  bus.mem_wdata,       0);
      check({tag, "_sha_start"},  32'(bus.sha_start),  0);
      check({tag, "_sha_active"}, 32'(bus.sha_active), 0);
      check({tag, "_out_valid"},  32'(bus.out_valid),  0);
      check({tag, "_out_data"},   bus.out_data,        0);
      check({tag, "_busy"},       32'(bus.busy),       0);
   endtask

   task automatic run_msg(input int base, input bit toggle, input int hi, input int lo,
                          input int pct, input logic [15:0] haddr, input bit go_mid);
      int  fa, la, guard, out_base, start_base, viol_base;
      wr_t w;
      eng_hi        = hi;
      eng_lo        = lo;
      rdy_pct       = pct;
      bus.hash_addr = haddr;
      for (int j = 0; j < 8; j++) begin
         preload(haddr + 16'(j), 32'h1111_1111 * 32'(j + 1));
         exp_out.push_back(32'h1111_1111 * 32'(j + 1));
      end
      for (int k = 0; k < NW; k++) begin
         w.addr = IN_ADDR + 16'(k);
         w.data = exp_word(base, k);
         exp_wr.push_back(w);
      end
      out_base   = out_total;
      start_base = start_total;
      viol_base  = low_viol;

      pulse_go();
      send_stream(base, toggle, 4*NW, fa, la);
      if (!toggle) check("stream_no_stall", 32'(la - fa), 32'(4*NW - 1));

      if (go_mid) begin
         guard = 0;
         while (bus.sha_done && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         repeat (20) @(negedge clk);
         pulse_go();
         @(negedge clk);
         check("go_ignored_in_ready", 32'(bus.in_ready), 0);
         check("go_ignored_busy", 32'(bus.busy), 1);
      end

      guard = 0;
      while ((out_total - out_base) < 8 && guard < 6000) begin
         @(negedge clk);
         guard++;
      end
      check("digest_count", 32'(out_total - out_base), 8);
      repeat (2) @(negedge clk);
      check("busy_after_digest", 32'(bus.busy), 0);
      check("start_pulses", 32'(start_total - start_base), 1);
      check("start_after_last_write", 32'(start_cyc), 32'(last_wr_cyc + 1));
      check("first_out_latency", 32'(first_out_cyc), 32'(done_rise_cyc + 3));
      check("engine_wait_outputs", 32'(low_viol - viol_base), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  fa, la, sb;
      wr_t w;
      bus.go         = 1'b0;
      bus.input_addr = IN_ADDR;
      bus.hash_addr  = 16'h0200;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Continuous byte stream 0x00..0x9F.
      run_msg(0, 1'b0, 3, 20, 100, 16'h0200, 1'b0);
      check("mem_word0", mem[IN_ADDR], 32'h0001_0203);
      check("mem_word39", mem[IN_ADDR + 16'd39], 32'h9C9D_9E9F);

      // Same stream with in_valid toggling every cycle.
      run_msg(0, 1'b1, 3, 20, 100, 16'h0200, 1'b0);

      // Long engine run, 30% consumer readiness, digest wrapping past 0xFFFF, go while waiting.
      run_msg(8'h20, 1'b0, 3, 500, 30, 16'hFFFC, 1'b1);

      // Reset after byte 50, then a fresh message.
      for (int k = 0; k < 12; k++) begin
         w.addr = IN_ADDR + 16'(k);
         w.data = exp_word(8'h40, k);
         exp_wr.push_back(w);
      end
      sb = start_total;
      pulse_go();
      send_stream(8'h40, 1'b0, 51, fa, la);
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("no_restart_after_reset", 32'(start_total - sb), 0);
      check("idle_after_reset", 32'(bus.busy), 0);
      check("partial_writes_drained", 32'(exp_wr.size()), 0);
      run_msg(8'h60, 1'b0, 3, 20, 50, 16'h0300, 1'b0);
      check("mem_word0_after_reset", mem[IN_ADDR], 32'h6061_6263);
      check("mem_word39_after_reset", mem[IN_ADDR + 16'd39], 32'hFCFD_FEFF);

      check("wr_queue_empty", 32'(exp_wr.size()), 0);
      check("out_queue_empty", 32'(exp_out.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sha256_msg_loader.md
Name: sha256_msg_loader

Overview:
Upstream controller and stream adapter for simplified_sha256. It accepts the message as a byte stream and packs it big-endian into 32-bit words. It writes those words into the shared message memory at input_addr, pulses the engine's start input, and waits for the engine's done. It then reads the 8 digest words back from hash_addr and emits them on a valid/ready output stream. The top level muxes memory ownership using sha_active.

Parameters:
NUM_OF_WORDS, 40, message length in 32-bit words; must equal the engine's NUM_OF_WORDS. Byte count is fixed at 4*NUM_OF_WORDS.
DIGEST_WORDS, 8, number of digest words read back; fixed at 8, not for override.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
go  in  1  single-cycle request to begin a new message; ignored unless busy=0
input_addr  in  16  memory base address for message words (constant during operation)
hash_addr  in  16  memory base address of digest (constant during operation)
in_valid  in  1  byte stream valid
in_data  in  8  message byte, stream order
in_ready  out  1  byte accepted when in_valid&in_ready
mem_we  out  1  memory write enable
mem_addr  out  16  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data; valid one cycle after the address is presented
sha_start  out  1  to engine start
sha_done  in  1  from engine done (high while engine idle)
sha_active  out  1  high from sha_start until the engine finishes; top level gives memory to engine
out_valid  out  1  digest word valid
out_data  out  32  digest word, H0 first
out_ready  in  1  digest consumer ready
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0) forces the FSM to IDLE. All outputs are 0 except mem_addr=0 and mem_wdata=0. The byte and word counters and the pack register are cleared. All outputs are registered.
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, RD_ADDR, RD_CAP, OUT.
- IDLE: in_ready=0. When go=1: clear counters and go to LOAD.
- LOAD: in_ready=1.
  - Each accepted byte shifts into the pack register; the first byte of a word lands in bits 31:24.
  - On acceptance of byte 3 of word k, the next cycle has mem_we=1, mem_addr=input_addr+k and mem_wdata equal to the packed word.
  - Writes never stall the byte stream; in_ready stays 1 through write cycles.
  - When the last byte (index 4*NUM_OF_WORDS-1) is accepted, in_ready drops the next cycle. The FSM goes to START after the final write cycle.
  - in_valid=0 simply holds the state; there is no timeout.
- START: sha_start=1 for exactly one cycle, mem_we=0, sha_active=1. Next state WAIT_BUSY.
- WAIT_BUSY: wait for sha_done=0, which confirms the engine left idle, then go to WAIT_DONE. sha_done is level-high before start, so a high sha_done in this state is never treated as completion.
- WAIT_DONE: wait for sha_done=1. Then sha_active=0 on the next cycle, the digest index i=0, and the FSM goes to RD_ADDR.
- RD_ADDR: mem_addr=hash_addr+i, mem_we=0. Next state RD_CAP.
- RD_CAP: capture mem_rdata into out_data, set out_valid=1, go to OUT.
- OUT: hold out_data and out_valid stable until out_ready=1.
  - On the handshake: out_valid=0 the next cycle.
  - If i<7: i=i+1 and go to RD_ADDR.
  - If i=7: go to IDLE.
  - Minimum spacing is 3 cycles per digest word.
- go while busy=1: ignored.
- rst_n low mid-operation: immediate return to IDLE. A partial message is discarded and sha_start is never reissued automatically.
- Address arithmetic is 16-bit modulo; wrap past 0xFFFF is permitted and not flagged.

Decomposition:
- Package sha256_pkg holds:
  - the FSM state enum (logic [2:0]);
  - the constant DIGEST_WORDS=8;
  - a helper function for the big-endian byte pack.
- One natural sub-module: sha256_byte_packer.
  - Takes byte valid/ready in; produces a word-valid pulse plus the 32-bit word and the word index.
  - It is instantiated in the loader; the FSM and memory/engine sequencing stay in sha256_msg_loader.

Test Plan:
1. Default params; go; stream bytes 0x00..0x9F with continuous valid -> 40 writes; word0=0x00010203 at input_addr; word39=0x9C9D9E9F at input_addr+39; sha_start one cycle after the final write.
2. Same stream with in_valid toggling 1/0 every cycle -> identical memory contents and write order; in_ready=0 after byte 159.
3. Engine model holds sha_done high for 3 cycles after start, then low for 500 cycles -> loader stays in WAIT_BUSY then WAIT_DONE and begins reads only after sha_done rises.
4. Digest memory preloaded with 0x11111111..0x88888888 at hash_addr; out_ready random 30% -> 8 words out in order 0x11111111 first; out_data stable while out_valid&!out_ready.
5. go asserted during WAIT_DONE -> no effect; busy stays 1; no second sha_start.
6. rst_n pulsed low after byte 50 -> all outputs 0 immediately; next go restarts at input_addr with word0 from the new stream.
